std_div_sched: RTL and testbench

STD_DIV_SCHED -- requirements
Module: std_div_sched

---
 rtl/std_div_sched.sv | 180 ++++++++++++++++++
 tb/tb_std_div_sched.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/std_div_sched.sv
// std_div_sched: round-robin request scheduler in front of one shared restoring divider.
// Optional macro STD_DIV_SCHED_DIVZERO_EN: zero divisor answers at once with resp_err set.
module std_div_sched #(
    parameter int width   = 32,
    parameter int num_req = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [num_req-1:0]       req_valid,
    output logic [num_req-1:0]       req_ready,
    input  logic [num_req-1:0]       req_op,
    input  logic [num_req*width-1:0] req_left,
    input  logic [num_req*width-1:0] req_right,
    output logic [num_req-1:0]       resp_valid,
    input  logic [num_req-1:0]       resp_ready,
    output logic [width-1:0]         resp_data,
    output logic                     resp_err,
    output logic                     busy
);
    localparam int IW = $clog2(num_req);
    localparam int CW = $clog2(width);
    localparam int RW = 2 * width - 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    grant_q, grant_d;
    logic             op_q, op_d;
    logic [RW-1:0]    rem_q, rem_d;
    logic [RW-1:0]    div_q, div_d;
    logic [width-2:0] quo_q, quo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [width-1:0] data_q, data_d;
`ifdef STD_DIV_SCHED_DIVZERO_EN
    logic             err_q, err_d;
`endif

    logic             pick_found;
    logic [IW-1:0]    pick_idx;
    int unsigned      idx;
    logic [width-1:0] acc_left;
    logic [width-1:0] acc_right;
    logic             rem_ge;
    logic [RW-1:0]    rem_sub;
    logic [width-1:0] quo_next;

    // Round-robin search starting at the priority pointer.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        for (int unsigned off = 0; off < num_req; off++) begin
            idx = (ptr_q + off) % num_req;
            if (!pick_found && req_valid[idx[IW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = idx[IW-1:0];
            end
        end
    end

    assign acc_left  = req_left[pick_idx*width +: width];
    assign acc_right = req_right[pick_idx*width +: width];

    assign rem_ge   = rem_q >= div_q;
    assign rem_sub  = rem_q - div_q;
    assign quo_next = {quo_q, rem_ge};

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        op_d       = op_q;
        rem_d      = rem_q;
        div_d      = div_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
`ifdef STD_DIV_SCHED_DIVZERO_EN
        err_d      = err_q;
`endif
        req_ready  = '0;
        resp_valid = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    req_ready[pick_idx] = 1'b1;
                    grant_d = pick_idx;
                    ptr_d   = (pick_idx == IW'(num_req - 1)) ? '0 : pick_idx + 1'b1;
                    op_d    = req_op[pick_idx];
                    rem_d   = {{(width-1){1'b0}}, acc_left};
                    div_d   = {acc_right, {(width-1){1'b0}}};
                    quo_d   = '0;
                    cnt_d   = '0;
                    data_d  = '0;
`ifdef STD_DIV_SCHED_DIVZERO_EN
                    err_d   = 1'b0;
`endif
                    if (acc_left == '0) begin
                        state_d = RESP;
`ifdef STD_DIV_SCHED_DIVZERO_EN
                    end else if (acc_right == '0) begin
                        state_d = RESP;
                        err_d   = 1'b1;
`endif
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (rem_ge) begin
                    rem_d = rem_sub;
                end
                quo_d = quo_next[width-2:0];
                div_d = div_q >> 1;
                cnt_d = cnt_q + 1'b1;
                // Final iteration: result is taken from this cycle's step, not the registers.
                if (cnt_q == CW'(width - 1)) begin
                    state_d = RESP;
                    if (op_q) begin
                        data_d = rem_ge ? rem_sub[width-1:0] : rem_q[width-1:0];
                    end else begin
                        data_d = quo_next;
                    end
                end
            end
            RESP: begin
                resp_valid[grant_q] = 1'b1;
                if (resp_ready[grant_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            op_q    <= 1'b0;
            rem_q   <= '0;
            div_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
`ifdef STD_DIV_SCHED_DIVZERO_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
`ifdef STD_DIV_SCHED_DIVZERO_EN
            err_q   <= err_d;
`endif
        end
    end

    assign resp_data = data_q;
    assign busy      = (state_q != IDLE);
`ifdef STD_DIV_SCHED_DIVZERO_EN
    assign resp_err  = err_q;
`else
    assign resp_err  = 1'b0;
`endif

endmodule

// File: tb/tb_std_div_sched.sv
// Self-checking bench for std_div_sched: arithmetic reference model plus a round-robin pointer model.
module tb_std_div_sched;
    localparam int W = 32;
    localparam int N = 4;
`ifdef STD_DIV_SCHED_DIVZERO_EN
    localparam bit DZ = 1'b1;
`else
    localparam bit DZ = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   req_op = '0;
    logic [N*W-1:0] req_left = '0;
    logic [N*W-1:0] req_right = '0;
    logic [N-1:0]   resp_valid;
    logic [N-1:0]   resp_ready = '0;
    logic [W-1:0]   resp_data;
    logic           resp_err;
    logic           busy;

    int checks = 0;
    int errors = 0;
    int ptr_m = 0;

    logic [N-1:0] pend = '0;
    logic         op_a    [N];
    logic [W-1:0] left_a  [N];
    logic [W-1:0] right_a [N];

    always #5 clk = ~clk;

    std_div_sched #(.width(W), .num_req(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_left   (req_left),
        .req_right  (req_right),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    function automatic logic [W-1:0] exp_data(input logic op, input logic [W-1:0] l, input logic [W-1:0] r);
        if (l == 0) return '0;
        if (r == 0) return DZ ? '0 : (op ? l : '1);
        return op ? (l % r) : (l / r);
    endfunction

    function automatic logic exp_err(input logic [W-1:0] l, input logic [W-1:0] r);
        return DZ && (l != 0) && (r == 0);
    endfunction

    function automatic int exp_latency(input logic [W-1:0] l, input logic [W-1:0] r);
        if (l == 0 || (DZ && r == 0)) return 1;
        return W + 1;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] mask);
        for (int off = 0; off < N; off++) begin
            if (mask[(ptr_m + off) % N]) return (ptr_m + off) % N;
        end
        return 0;
    endfunction

    task automatic set_req(input int i, input logic op, input logic [W-1:0] l, input logic [W-1:0] r);
        op_a[i]    = op;
        left_a[i]  = l;
        right_a[i] = r;
        req_op[i]  = op;
        req_left[i*W +: W]  = l;
        req_right[i*W +: W] = r;
    endtask

    task automatic rand_req(input int i);
        logic [W-1:0] l;
        logic [W-1:0] r;
        l = $urandom;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: l = '0;
            1: r = '0;
            2: r = 1;
            3: r = $urandom_range(1, 255);
            4: r = l + 1;
            5: l = '1;
            default: ;
        endcase
        set_req(i, 1'($urandom_range(0, 1)), l, r);
    endtask

    // Entered at negedge+1 with req_valid == pend; serves every pending request in model order.
    task automatic serve_pending(input int hold_mode);
        int           g;
        int           lat;
        int           hold;
        int           want_lat;
        logic [W-1:0] ed;
        logic         ee;
        logic [N-1:0] onehot;
        while (pend != '0) begin
            g = rr_pick(pend);
            onehot = '0;
            onehot[g] = 1'b1;
            ed = exp_data(op_a[g], left_a[g], right_a[g]);
            ee = exp_err(left_a[g], right_a[g]);
            want_lat = exp_latency(left_a[g], right_a[g]);
            checks++;
            if (req_ready !== onehot) begin
                errors++;
                $display("FAIL grant: req_ready=%b expected %b", req_ready, onehot);
            end
            @(negedge clk);
            pend[g] = 1'b0;
            req_valid = pend;
            ptr_m = (g + 1) % N;
            lat = 1;
            #1;
            while (resp_valid === '0 && lat < W + 8) begin
                @(negedge clk);
                lat++;
                #1;
            end
            checks++;
            if (lat != want_lat) begin
                errors++;
                $display("FAIL latency: req%0d got %0d cycles expected %0d", g, lat, want_lat);
            end
            checks++;
            if (resp_valid !== onehot) begin
                errors++;
                $display("FAIL resp_valid: got %b expected %b", resp_valid, onehot);
            end
            checks++;
            if (resp_data !== ed) begin
                errors++;
                $display("FAIL resp_data: req%0d op=%0d %h,%h got %h expected %h",
                         g, op_a[g], left_a[g], right_a[g], resp_data, ed);
            end
            checks++;
            if (resp_err !== ee) begin
                errors++;
                $display("FAIL resp_err: got %b expected %b", resp_err, ee);
            end
            checks++;
            if (req_ready !== '0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL resp_state: req_ready=%b busy=%b expected 0000/1", req_ready, busy);
            end
            hold = (hold_mode < 0) ? $urandom_range(0, 3) : hold_mode;
            for (int h = 0; h < hold; h++) begin
                resp_ready = N'($urandom) & ~onehot;
                @(negedge clk);
                #1;
                checks++;
                if (resp_valid !== onehot || resp_data !== ed || resp_err !== ee || req_ready !== '0) begin
                    errors++;
                    $display("FAIL hold: cyc %0d valid=%b data=%h err=%b ready=%b expected %b %h %b 0",
                             h, resp_valid, resp_data, resp_err, req_ready, onehot, ed, ee);
                end
            end
            resp_ready = N'($urandom) | onehot;
            @(negedge clk);
            #1;
            resp_ready = '0;
            checks++;
            if (resp_valid !== '0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL release: resp_valid=%b busy=%b expected 0/0", resp_valid, busy);
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ptr_m = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (resp_valid !== '0 || resp_data !== '0 || resp_err !== 1'b0 || busy !== 1'b0 || req_ready !== '0) begin
            errors++;
            $display("FAIL reset_hold: valid=%b data=%h err=%b busy=%b ready=%b expected zeros",
                     resp_valid, resp_data, resp_err, busy, req_ready);
        end
        reset = 1'b0;
        ptr_m = 0;
        @(negedge clk);
        #1;
        checks++;
        if (resp_valid !== '0 || resp_data !== '0 || busy !== 1'b0 || req_ready !== '0) begin
            errors++;
            $display("FAIL reset_release: valid=%b data=%h busy=%b ready=%b expected zeros",
                     resp_valid, resp_data, busy, req_ready);
        end
    endtask

    task automatic issue(input int i, input logic op, input logic [W-1:0] l, input logic [W-1:0] r, input int hold);
        @(negedge clk);
        set_req(i, op, l, r);
        pend = '0;
        pend[i] = 1'b1;
        req_valid = pend;
        #1;
        serve_pending(hold);
    endtask

    task automatic test_directed();
        issue(0, 1'b0, 32'd100, 32'd7, 0);
        issue(2, 1'b1, 32'd100, 32'd7, 0);
        issue(1, 1'b1, 32'hFFFF_FFFF, 32'h0001_0000, 0);
        issue(3, 1'b0, 32'd5, 32'd9, 0);
        issue(0, 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
    endtask

    task automatic test_round_robin();
        pulse_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'd1000 + 32'(i), 32'd3 + 32'(i));
        pend = '1;
        req_valid = pend;
        #1;
        checks++;
        if (req_ready !== N'(1)) begin
            errors++;
            $display("FAIL rr_first: req_ready=%b expected 0001", req_ready);
        end
        serve_pending(0);
        @(negedge clk);
        pend = '0;
        pend[1] = 1'b1;
        pend[3] = 1'b1;
        set_req(1, 1'b1, 32'd77, 32'd10);
        set_req(3, 1'b0, 32'd77, 32'd10);
        req_valid = pend;
        #1;
        serve_pending(0);
    endtask

    task automatic test_divzero();
        issue(2, 1'b0, 32'd9, 32'd0, 0);
        issue(1, 1'b1, 32'd9, 32'd0, 0);
        issue(0, 1'b1, 32'd0, 32'd0, 0);
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        set_req(0, 1'b0, 32'd123456, 32'd789);
        set_req(3, 1'b1, 32'd123456, 32'd789);
        pend = '0;
        pend[0] = 1'b1;
        pend[3] = 1'b1;
        req_valid = pend;
        #1;
        serve_pending(10);
        issue(2, 1'b0, 32'd0, 32'd55, 10);
    endtask

    task automatic test_reset_mid_calc();
        logic [N-1:0] seen;
        @(negedge clk);
        set_req(2, 1'b0, 32'd1000, 32'd3);
        pend = '0;
        pend[2] = 1'b1;
        req_valid = pend;
        #1;
        checks++;
        if (req_ready !== pend) begin
            errors++;
            $display("FAIL midcalc_grant: req_ready=%b expected %b", req_ready, pend);
        end
        @(negedge clk);
        pend = '0;
        req_valid = '0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (resp_valid !== '0 || resp_data !== '0 || resp_err !== 1'b0 || busy !== 1'b0 || req_ready !== '0) begin
            errors++;
            $display("FAIL midcalc_reset: valid=%b data=%h err=%b busy=%b ready=%b expected zeros",
                     resp_valid, resp_data, resp_err, busy, req_ready);
        end
        reset = 1'b0;
        ptr_m = 0;
        seen = '0;
        for (int c = 0; c < W + 5; c++) begin
            @(negedge clk);
            #1;
            seen = seen | resp_valid;
        end
        checks++;
        if (seen !== '0) begin
            errors++;
            $display("FAIL midcalc_noresp: resp_valid seen %b expected 0000", seen);
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) rand_req(i);
        pend = '1;
        req_valid = pend;
        #1;
        checks++;
        if (req_ready !== N'(1)) begin
            errors++;
            $display("FAIL midcalc_regrant: req_ready=%b expected 0001", req_ready);
        end
        serve_pending(0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            @(negedge clk);
            pend = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                if (pend[i]) rand_req(i);
            end
            req_valid = pend;
            #1;
            serve_pending(-1);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_round_robin();
        test_divzero();
        test_backpressure();
        test_reset_mid_calc();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
